fu_wb_arbiter: RTL and testbench

- Collects completion results from NUM_FU functional units and serialises them onto a single writeback/completion port feeding the register file and ROB.
- Each FU has a one-entry holding slot. A round-robin arbiter moves slots into a registered output stage.
- Back-pressure reaches the FUs through per-FU stall signals.
- Sits between the FU output side of fu_if (ctrl modport) and the writeback/ROB-complete logic.

---
 rtl/fu_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_fu_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_wb_arbiter.sv
// Purpose : serialise completion results from NUM_FU functional units onto one
//           writeback/ROB-complete port via per-FU holding slots and a
//           round-robin arbiter feeding a registered output stage.
// Latency : fu_out_valid in cycle N -> wb_valid in cycle N+2 when uncontended;
//           one entry per cycle sustained.
// Backpressure: wb_ready low freezes the output stage; a full slot that is not
//           granted raises fu_stall[i] combinationally so FU i holds its result.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous flush, drops all held results
//   fu_out_*            per-FU result presentation (valid, id, lanes, PRNs)
//   fu_stall            per-FU hold request
//   wb_valid/wb_ready   output handshake
//   wb_*                registered writeback entry and its source FU index
module fu_wb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    localparam int IDX_BITS    = $clog2(NUM_FU)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [NUM_FU-1:0]                             fu_out_valid,
    input  logic [NUM_FU-1:0][INST_ID_BITS-1:0]           fu_out_inst_id,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]     fu_out_data,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0]           fu_out_data_valid,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_out_prn,
    output logic [NUM_FU-1:0]                             fu_stall,
    output logic                                          wb_valid,
    input  logic                                          wb_ready,
    output logic [INST_ID_BITS-1:0]                       wb_inst_id,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]         wb_prn,
    output logic [MAX_OPERANDS-1:0][63:0]                 wb_data,
    output logic [MAX_OPERANDS-1:0]                       wb_data_valid,
    output logic [IDX_BITS-1:0]                           wb_fu_idx
);

    // Holding slots, one per FU
    logic [NUM_FU-1:0]                                 slot_valid;
    logic [NUM_FU-1:0][INST_ID_BITS-1:0]               slot_inst_id;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]         slot_data;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0]               slot_data_valid;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] slot_prn;

    logic [IDX_BITS-1:0] rr_ptr;
    logic                out_free;
    logic                grant_vld;
    logic [IDX_BITS-1:0] grant_idx;
    logic [IDX_BITS-1:0] scan_idx;
    logic [NUM_FU-1:0]   grant_oh;
    logic [NUM_FU-1:0]   capture;
    logic [IDX_BITS-1:0] rr_next;

    assign out_free = !wb_valid || wb_ready;

    // Round-robin search starting at rr_ptr; first valid slot wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = IDX_BITS'((int'(rr_ptr) + k) % NUM_FU);
            if (!grant_vld && slot_valid[scan_idx] && out_free && !flush) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A granted slot frees this cycle, so its FU may hand over the next
    // result immediately. Flush forces stall low so FUs are not held.
    assign fu_stall = slot_valid & ~grant_oh & {NUM_FU{~flush}};
    assign capture  = fu_out_valid & ~fu_stall & {NUM_FU{~flush}};

    // Explicit wrap keeps non-power-of-two NUM_FU correct.
    assign rr_next = (grant_idx == IDX_BITS'(NUM_FU - 1)) ? '0
                                                           : grant_idx + IDX_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid      <= '0;
            slot_inst_id    <= '0;
            slot_data       <= '0;
            slot_data_valid <= '0;
            slot_prn        <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (flush) begin
                    slot_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    // Covers capture-while-granted: old contents leave via
                    // the output stage, new contents take the slot.
                    slot_valid[i]      <= 1'b1;
                    slot_inst_id[i]    <= fu_out_inst_id[i];
                    slot_data[i]       <= fu_out_data[i];
                    slot_data_valid[i] <= fu_out_data_valid[i];
                    slot_prn[i]        <= fu_out_prn[i];
                end else if (grant_oh[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            wb_valid      <= 1'b0;
            wb_inst_id    <= '0;
            wb_prn        <= '0;
            wb_data       <= '0;
            wb_data_valid <= '0;
            wb_fu_idx     <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (grant_vld) begin
            wb_valid      <= 1'b1;
            wb_inst_id    <= slot_inst_id[grant_idx];
            wb_prn        <= slot_prn[grant_idx];
            wb_data       <= slot_data[grant_idx];
            wb_data_valid <= slot_data_valid[grant_idx];
            wb_fu_idx     <= grant_idx;
            rr_ptr        <= rr_next;
        end else if (wb_valid && wb_ready) begin
            // Data fields intentionally keep their last value.
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
module tb_fu_wb_arbiter;
    localparam int NF = 4;
    localparam int IB = 6;
    localparam int PB = 6;
    localparam int MO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [NF-1:0]                     fu_out_valid = '0;
    logic [NF-1:0][IB-1:0]             fu_out_inst_id = '0;
    logic [NF-1:0][MO-1:0][63:0]       fu_out_data = '0;
    logic [NF-1:0][MO-1:0]             fu_out_data_valid = '0;
    logic [NF-1:0][MO-1:0][PB-1:0]     fu_out_prn = '0;
    logic [NF-1:0]                     fu_stall;
    logic                              wb_valid;
    logic                              wb_ready = 1'b1;
    logic [IB-1:0]                     wb_inst_id;
    logic [MO-1:0][PB-1:0]             wb_prn;
    logic [MO-1:0][63:0]               wb_data;
    logic [MO-1:0]                     wb_data_valid;
    logic [1:0]                        wb_fu_idx;

    fu_wb_arbiter #(.NUM_FU(NF), .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_out_valid(fu_out_valid), .fu_out_inst_id(fu_out_inst_id),
        .fu_out_data(fu_out_data), .fu_out_data_valid(fu_out_data_valid),
        .fu_out_prn(fu_out_prn), .fu_stall(fu_stall),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
        .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_data_valid),
        .wb_fu_idx(wb_fu_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            fu;
        logic [IB-1:0] id;
        logic [PB-1:0] prn0;
        logic [63:0]   d0;
        logic [MO-1:0] dv;
        logic [1:0]    exp_idx;
    } vec_t;

    typedef struct {
        logic [IB-1:0]         id;
        logic [1:0]            fu;
        logic [MO-1:0][PB-1:0] prn;
        logic [MO-1:0][63:0]   data;
        logic [MO-1:0]         dv;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lanes are derived from prn0/d0 so every lane carries distinct content.
    task automatic set_fu(input int fu, input logic [IB-1:0] id, input logic [PB-1:0] prn0,
                          input logic [63:0] d0, input logic [MO-1:0] dv);
        fu_out_valid[fu]      = 1'b1;
        fu_out_inst_id[fu]    = id;
        fu_out_data_valid[fu] = dv;
        for (int l = 0; l < MO; l++) begin
            fu_out_prn[fu][l]  = prn0 + PB'(l);
            fu_out_data[fu][l] = d0 + 64'(l);
        end
    endtask

    task automatic push_exp(input logic [1:0] fu, input logic [IB-1:0] id, input logic [PB-1:0] prn0,
                            input logic [63:0] d0, input logic [MO-1:0] dv);
        exp_t e;
        e.id = id; e.fu = fu; e.dv = dv;
        for (int l = 0; l < MO; l++) begin
            e.prn[l]  = prn0 + PB'(l);
            e.data[l] = d0 + 64'(l);
        end
        sb.push_back(e);
    endtask

    task automatic send(input int fu, input logic [IB-1:0] id);
        set_fu(fu, id, id, {58'h0, id} * 64'h101, 3'b101);
        push_exp(2'(fu), id, id, {58'h0, id} * 64'h101, 3'b101);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_entry", {186'h0, wb_inst_id}, 192'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_inst_id", 192'(wb_inst_id), 192'(e.id));
                chk("sb_fu_idx", 192'(wb_fu_idx), 192'(e.fu));
                chk("sb_prn", 192'(wb_prn), 192'(e.prn));
                chk("sb_data", 192'(wb_data), 192'(e.data));
                chk("sb_dv", 192'(wb_data_valid), 192'(e.dv));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = '{fu: 0, id: 6'd5,  prn0: 6'd10, d0: 64'hDEAD,                dv: 3'b001, exp_idx: 2'd0};
        vecs[1] = '{fu: 2, id: 6'd17, prn0: 6'd33, d0: 64'h0123_4567_89AB_CDEF, dv: 3'b111, exp_idx: 2'd2};
        vecs[2] = '{fu: 1, id: 6'd42, prn0: 6'd1,  d0: 64'hFFFF_FFFF_FFFF_FFF0, dv: 3'b010, exp_idx: 2'd1};
        vecs[3] = '{fu: 3, id: 6'd63, prn0: 6'd60, d0: 64'h0,                   dv: 3'b000, exp_idx: 2'd3};

        // Reset state
        #2;
        chk("rst_wb_valid", 192'(wb_valid), 192'h0);
        chk("rst_fu_stall", 192'(fu_stall), 192'h0);
        chk("rst_wb_inst_id", 192'(wb_inst_id), 192'h0);
        chk("rst_wb_data", 192'(wb_data), 192'h0);
        chk("rst_wb_fu_idx", 192'(wb_fu_idx), 192'h0);
        cyc(); cyc();
        rst = 1'b0;

        // Table: isolated results, 2-cycle latency, 1-cycle valid pulse
        for (int v = 0; v < 4; v++) begin
            cyc();
            set_fu(vecs[v].fu, vecs[v].id, vecs[v].prn0, vecs[v].d0, vecs[v].dv);
            push_exp(vecs[v].exp_idx, vecs[v].id, vecs[v].prn0, vecs[v].d0, vecs[v].dv);
            cyc();
            fu_out_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_c2_wb_valid", v), 192'(wb_valid), 192'h0);
            cyc();
            @(negedge clk);
            chk($sformatf("vec%0d_c3_wb_valid", v), 192'(wb_valid), 192'h1);
            cyc();
            @(negedge clk);
            chk($sformatf("vec%0d_c4_wb_valid", v), 192'(wb_valid), 192'h0);
        end

        // Contention: all four in one cycle, rr_ptr is 0 after FU3's grant
        cyc();
        for (int f = 0; f < NF; f++) send(f, IB'(f + 1));
        for (int c = 2; c <= 7; c++) begin
            cyc();
            fu_out_valid = '0;
            @(negedge clk);
            chk($sformatf("cont_c%0d_stall3", c), 192'(fu_stall[3]), 192'((c <= 4) ? 1 : 0));
            chk($sformatf("cont_c%0d_wb_valid", c), 192'(wb_valid), 192'((c >= 3 && c <= 6) ? 1 : 0));
            if (c >= 3 && c <= 6)
                chk($sformatf("cont_c%0d_fu_idx", c), 192'(wb_fu_idx), 192'(c - 3));
        end

        // Fairness: FU0 and FU1 always have a result; FUs advance when not stalled
        begin
            int n0, n1;
            logic a0, a1;
            n0 = 0; n1 = 0;
            for (int k = 0; k < 4; k++) begin
                push_exp(2'd0, IB'(10 + k), IB'(10 + k), 64'(10 + k) * 64'h101, 3'b101);
                push_exp(2'd1, IB'(30 + k), IB'(30 + k), 64'(30 + k) * 64'h101, 3'b101);
            end
            for (int c = 1; c <= 11; c++) begin
                cyc();
                fu_out_valid = '0;
                if (n0 < 4) set_fu(0, IB'(10 + n0), IB'(10 + n0), 64'(10 + n0) * 64'h101, 3'b101);
                if (n1 < 4) set_fu(1, IB'(30 + n1), IB'(30 + n1), 64'(30 + n1) * 64'h101, 3'b101);
                @(negedge clk);
                a0 = fu_out_valid[0] && !fu_stall[0];
                a1 = fu_out_valid[1] && !fu_stall[1];
                if (a0) n0++;
                if (a1) n1++;
                if (c >= 3 && c <= 10) begin
                    chk($sformatf("fair_c%0d_wb_valid", c), 192'(wb_valid), 192'h1);
                    chk($sformatf("fair_c%0d_fu_idx", c), 192'(wb_fu_idx), 192'((c - 3) % 2));
                end
            end
            fu_out_valid = '0;
        end

        // Back-pressure: FU2 entry held while wb_ready low, later results queue
        cyc();
        send(2, 6'd20);
        cyc();
        fu_out_valid = '0;
        wb_ready = 1'b0;
        cyc();
        send(2, 6'd21);
        cyc();
        set_fu(2, 6'd22, 6'd22, 64'd22 * 64'h101, 3'b101);
        push_exp(2'd2, 6'd22, 6'd22, 64'd22 * 64'h101, 3'b101);
        for (int c = 4; c <= 6; c++) begin
            if (c > 4) cyc();
            @(negedge clk);
            chk($sformatf("bp_c%0d_stall2", c), 192'(fu_stall[2]), 192'h1);
            chk($sformatf("bp_c%0d_wb_valid", c), 192'(wb_valid), 192'h1);
            chk($sformatf("bp_c%0d_wb_id", c), 192'(wb_inst_id), 192'd20);
        end
        cyc();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_c7_stall2", 192'(fu_stall[2]), 192'h0);
        cyc();
        fu_out_valid = '0;
        @(negedge clk);
        chk("bp_c8_wb_id", 192'(wb_inst_id), 192'd21);
        cyc();
        @(negedge clk);
        chk("bp_c9_wb_id", 192'(wb_inst_id), 192'd22);
        cyc();
        @(negedge clk);
        chk("bp_c10_wb_valid", 192'(wb_valid), 192'h0);

        // Flush with slots full and output held
        cyc();
        wb_ready = 1'b0;
        for (int f = 0; f < NF; f++) set_fu(f, IB'(40 + f), 6'd0, 64'h0, 3'b000);
        cyc();
        fu_out_valid = '0;
        cyc();
        flush = 1'b1;
        set_fu(0, 6'd49, 6'd0, 64'h0, 3'b001);
        @(negedge clk);
        chk("flush_c3_stall", 192'(fu_stall), 192'h0);
        chk("flush_c3_wb_valid_before", 192'(wb_valid), 192'h1);
        cyc();
        flush = 1'b0;
        fu_out_valid = '0;
        wb_ready = 1'b1;
        send(1, 6'd50);
        @(negedge clk);
        chk("flush_c4_wb_valid", 192'(wb_valid), 192'h0);
        chk("flush_c4_stall", 192'(fu_stall), 192'h0);
        cyc();
        fu_out_valid = '0;
        @(negedge clk);
        chk("flush_c5_wb_valid", 192'(wb_valid), 192'h0);
        cyc();
        @(negedge clk);
        chk("flush_c6_wb_valid", 192'(wb_valid), 192'h1);
        chk("flush_c6_wb_id", 192'(wb_inst_id), 192'd50);
        cyc();
        @(negedge clk);
        chk("flush_c7_wb_valid", 192'(wb_valid), 192'h0);

        // Asynchronous reset between edges while an entry is held
        cyc();
        wb_ready = 1'b0;
        set_fu(0, 6'd7, 6'd0, 64'h0, 3'b001);
        set_fu(1, 6'd8, 6'd0, 64'h0, 3'b001);
        cyc();
        fu_out_valid = '0;
        cyc();
        @(negedge clk);
        chk("arst_pre_wb_valid", 192'(wb_valid), 192'h1);
        chk("arst_pre_stall1", 192'(fu_stall[1]), 192'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wb_valid", 192'(wb_valid), 192'h0);
        chk("arst_stall", 192'(fu_stall), 192'h0);
        chk("arst_wb_id", 192'(wb_inst_id), 192'h0);
        cyc();
        rst = 1'b0;
        wb_ready = 1'b1;
        cyc();
        set_fu(0, 6'd5, 6'd10, 64'hDEAD, 3'b001);
        push_exp(2'd0, 6'd5, 6'd10, 64'hDEAD, 3'b001);
        cyc();
        fu_out_valid = '0;
        cyc();
        @(negedge clk);
        chk("post_rst_c3_wb_valid", 192'(wb_valid), 192'h1);
        chk("post_rst_c3_data0", 192'(wb_data[0]), 192'h0000DEAD);
        cyc();
        @(negedge clk);
        chk("post_rst_c4_wb_valid", 192'(wb_valid), 192'h0);

        cyc();
        chk("sb_drained", 192'(sb.size()), 192'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
